// File: rtl/anita3_scaler_pkg.sv
// anita3_scaler_pkg: sweep addresses, frame size and FSM states shared by the scaler reader
package anita3_scaler_pkg;
    localparam logic [5:0] L3_BASE = 6'h10;
    localparam logic [5:0] C3PO_ADDR = 6'h27;
    localparam logic [5:0] SEC_ADDR = 6'h29;
    localparam int NWORDS = 18;
    localparam logic [7:0] HDR_MARK_DEF = 8'hA3;

    typedef enum logic [1:0] {IDLE, SETTLE, SCAN, COMMIT} state_t;

    // Scaler address of sweep word k; past the end it parks on the L3 base
    function automatic logic [5:0] sweep_addr(input logic [4:0] k);
        return k < 5'd16 ? L3_BASE | {2'b00, k[3:0]} :
               k == 5'd16 ? C3PO_ADDR :
               k == 5'd17 ? SEC_ADDR : L3_BASE;
    endfunction
endpackage

// File: rtl/anita3_scaler_dpram.sv
// anita3_scaler_dpram: 64x32 simple dual-port RAM, registered read, address MSB selects the bank
module anita3_scaler_dpram (
    input  logic        clk,
    input  logic        we,
    input  logic [5:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [5:0]  raddr,
    output logic [31:0] rdata
);
    logic [31:0] mem [64];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/anita3_scaler_reader.sv
// anita3_scaler_reader: per-PPS sweep of the scaler bus into a double-buffered frame store,
// streamed out as header + 18 words over valid/ready.
module anita3_scaler_reader
    import anita3_scaler_pkg::*;
#(
    parameter int         SETTLE_CYCLES = 4,
    parameter logic [7:0] HDR_MARK = HDR_MARK_DEF
) (
    input  logic        clk33_i,
    input  logic        rst_i,
    input  logic        pps_i,
    output logic [5:0]  scal_addr_o,
    input  logic [31:0] scal_dat_i,
    output logic [31:0] m_dat_o,
    output logic        m_valid_o,
    output logic        m_last_o,
    input  logic        m_ready_i,
    output logic [15:0] frame_cnt_o,
    output logic        busy_o
);
    state_t state, state_n;
    logic pps_r, pps_d, pps_edge;
    logic [15:0] settle_cnt;
    logic [4:0] widx, nxt, nxt_n;
    logic rd_bank, rd_full, drop, wr_en, commit_ok, drop_evt, load, hdr_acc, last_acc;
    logic [31:0] rdata;

    assign pps_edge = pps_r & ~pps_d;

    always_ff @(posedge clk33_i) begin
        if (rst_i) state <= IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (pps_edge) state_n = SETTLE_CYCLES == 0 ? SCAN : SETTLE;
            SETTLE:  if (settle_cnt == 16'(SETTLE_CYCLES - 1)) state_n = SCAN;
            SCAN:    if (widx == 5'(NWORDS - 1)) state_n = COMMIT;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy_o = state == SETTLE || state == SCAN;
        wr_en = state == SCAN;
        commit_ok = state == COMMIT && !rd_full;
        drop_evt = (pps_edge && state != IDLE) || (state == COMMIT && rd_full);
    end

    always_ff @(posedge clk33_i) begin
        if (rst_i) begin
            pps_r <= 1'b0;
            pps_d <= 1'b0;
            settle_cnt <= '0;
            widx <= '0;
            scal_addr_o <= L3_BASE;
        end else begin
            pps_r <= pps_i;
            pps_d <= pps_r;
            settle_cnt <= state == SETTLE ? settle_cnt + 16'd1 : '0;
            widx <= state == SCAN ? widx + 5'd1 : '0;
            scal_addr_o <= state == SCAN ? sweep_addr(widx + 5'd1) : L3_BASE;
        end
    end

    // nxt is the stream index of the next word to load (0 = header); the RAM is addressed
    // with the post-load index so its registered output is ready when the next slot opens.
    assign load = rd_full & (nxt <= 5'(NWORDS)) & (~m_valid_o | m_ready_i);
    assign nxt_n = load ? nxt + 5'd1 : nxt;
    assign hdr_acc = m_valid_o & m_ready_i & (nxt == 5'd1);
    assign last_acc = m_valid_o & m_ready_i & m_last_o;

    anita3_scaler_dpram ram (
        .clk(clk33_i),
        .we(wr_en),
        .waddr({~rd_bank, widx}),
        .wdata(scal_dat_i),
        .raddr({rd_bank, nxt_n - 5'd1}),
        .rdata(rdata)
    );

    always_ff @(posedge clk33_i) begin
        if (rst_i) begin
            rd_bank <= 1'b0;
            rd_full <= 1'b0;
            nxt <= '0;
            drop <= 1'b0;
            frame_cnt_o <= '0;
            m_valid_o <= 1'b0;
            m_last_o <= 1'b0;
            m_dat_o <= '0;
        end else begin
            rd_bank <= commit_ok ? ~rd_bank : rd_bank;
            rd_full <= commit_ok | (rd_full & ~last_acc);
            nxt <= last_acc ? 5'd0 : nxt_n;
            frame_cnt_o <= frame_cnt_o + 16'(commit_ok);
            // Only the drop the accepted header actually reported is cleared
            drop <= drop_evt | (drop & ~(hdr_acc & m_dat_o[23]));
            if (load) begin
                m_valid_o <= 1'b1;
                m_last_o <= nxt == 5'(NWORDS);
                m_dat_o <= nxt == 5'd0 ? {HDR_MARK, drop, 7'b0, frame_cnt_o} : rdata;
            end else if (m_ready_i) begin
                m_valid_o <= 1'b0;
                m_last_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_anita3_scaler_reader.sv
// tb_anita3_scaler_reader: table-driven sweep timing checks plus a scoreboard on the frame stream
module tb_anita3_scaler_reader;
    logic clk33 = 1'b0, rst = 1'b1, pps = 1'b0, m_ready = 1'b0;
    logic [5:0] scal_addr;
    logic [31:0] scal_dat, m_dat;
    logic m_valid, m_last, busy;
    logic [15:0] frame_cnt;
    int total = 0, bad = 0;
    int rmode = 1;
    logic [32:0] sb[$];
    logic [32:0] want;
    logic pv = 1'b0, pr = 1'b0, prst = 1'b1, plast = 1'b0;
    logic [31:0] pdat = '0;

    typedef struct {
        int         off;
        logic [5:0] addr;
        logic       busy;
        logic       valid;
    } vec_t;
    vec_t tbl[25];

    anita3_scaler_reader dut (
        .clk33_i(clk33),
        .rst_i(rst),
        .pps_i(pps),
        .scal_addr_o(scal_addr),
        .scal_dat_i(scal_dat),
        .m_dat_o(m_dat),
        .m_valid_o(m_valid),
        .m_last_o(m_last),
        .m_ready_i(m_ready),
        .frame_cnt_o(frame_cnt),
        .busy_o(busy)
    );

    assign scal_dat = {26'h0, scal_addr};
    always #15 clk33 = ~clk33;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One clock per iteration; ready follows rmode (0 stall, 1 always, 2 toggle)
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk33);
            #1;
            m_ready = rmode == 2 ? ~m_ready : rmode == 1;
        end
    endtask

    // Returns one ns after t0, the edge where the registered PPS first reads high
    task automatic pulse;
        pps = 1'b1;
        step(1);
        pps = 1'b0;
    endtask

    task automatic push_frame(input logic [15:0] cnt, input logic drop);
        sb.push_back({1'b0, 8'hA3, drop, 7'b0, cnt});
        for (int k = 0; k < 18; k++)
            sb.push_back({k == 17, 26'h0, 6'(k < 16 ? 16 + k : k == 16 ? 39 : 41)});
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_valid"}, m_valid, 0);
        chk({name, "_last"}, m_last, 0);
        chk({name, "_dat"}, m_dat, 0);
        chk({name, "_cnt"}, frame_cnt, 0);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_addr"}, scal_addr, 6'h10);
    endtask

    task automatic do_reset(input string name);
        rst = 1'b1;
        sb.delete();
        step(1);
        chk_reset(name);
        rst = 1'b0;
        step(2);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            step(1);
            n++;
        end
        chk({name, "_drain"}, sb.size(), 0);
        step(3);
        chk({name, "_idle"}, m_valid, 0);
    endtask

    always @(negedge clk33) begin
        if (!rst && !prst && pv && !pr)
            chk("stall_hold", {m_valid, m_last, m_dat}, {1'b1, plast, pdat});
        if (!rst && m_valid && m_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_word: got %h want none", m_dat);
            end else begin
                want = sb.pop_front();
                chk("stream_word", {m_last, m_dat}, want);
            end
        end
        pv <= m_valid;
        pr <= m_ready;
        prst <= rst;
        pdat <= m_dat;
        plast <= m_last;
    end

    initial begin
        for (int i = 0; i < 25; i++) begin
            tbl[i].off = i + 1;
            tbl[i].addr = (i + 1 >= 5 && i + 1 <= 20) ? 6'(16 + i - 4) :
                          i + 1 == 21 ? 6'h27 : i + 1 == 22 ? 6'h29 : 6'h10;
            tbl[i].busy = i + 1 <= 22;
            tbl[i].valid = i + 1 >= 25;
        end

        step(2);
        do_reset("rst0");

        // Single PPS, ready high: sweep addresses, busy window, first valid at t0+25
        push_frame(16'd1, 1'b0);
        pulse;
        begin
            int cur = 0;
            for (int i = 0; i < 25; i++) begin
                step(tbl[i].off - cur);
                cur = tbl[i].off;
                chk($sformatf("addr_t%0d", cur), scal_addr, tbl[i].addr);
                chk($sformatf("busy_t%0d", cur), busy, tbl[i].busy);
                chk($sformatf("valid_t%0d", cur), m_valid, tbl[i].valid);
            end
        end
        drain("single");
        chk("single_cnt", frame_cnt, 1);

        // Ready toggling every cycle
        rmode = 2;
        push_frame(16'd2, 1'b0);
        pulse;
        drain("toggle");
        chk("toggle_cnt", frame_cnt, 2);

        // Ready low across three PPS: frame 1 pending, the next two dropped
        rmode = 1;
        do_reset("rst1");
        rmode = 0;
        push_frame(16'd1, 1'b0);
        pulse;
        step(40);
        pulse;
        step(40);
        pulse;
        step(40);
        chk("held_cnt", frame_cnt, 1);
        chk("held_valid", m_valid, 1);
        chk("held_hdr", m_dat, 32'hA300_0001);
        rmode = 1;
        drain("held");
        push_frame(16'd2, 1'b1);
        pulse;
        drain("after_drop");
        push_frame(16'd3, 1'b0);
        pulse;
        drain("drop_cleared");

        // PPS during SCAN: ignored, address keeps counting, drop flagged in header
        do_reset("rst2");
        push_frame(16'd1, 1'b1);
        pulse;
        step(6);
        pulse;
        chk("scan_pps_addr0", scal_addr, 6'h12);
        step(1);
        chk("scan_pps_addr1", scal_addr, 6'h13);
        drain("scan_pps");
        chk("scan_pps_cnt", frame_cnt, 1);
        push_frame(16'd2, 1'b0);
        pulse;
        drain("scan_pps_next");

        // Reset mid-SCAN, then mid-stream
        do_reset("rst3");
        pulse;
        step(10);
        chk("midscan_busy", busy, 1);
        rst = 1'b1;
        step(1);
        chk_reset("midscan");
        rst = 1'b0;
        step(40);
        chk("midscan_quiet", m_valid, 0);
        rmode = 0;
        pulse;
        step(30);
        chk("midstream_valid", m_valid, 1);
        rst = 1'b1;
        step(1);
        chk_reset("midstream");
        rst = 1'b0;
        rmode = 1;
        step(30);
        chk("midstream_quiet", m_valid, 0);
        push_frame(16'd1, 1'b0);
        pulse;
        drain("post_rst");

        // Frame counter wrap from 0xFFFF
        do_reset("rst4");
        force dut.frame_cnt_o = 16'hFFFF;
        step(1);
        release dut.frame_cnt_o;
        step(1);
        push_frame(16'h0000, 1'b0);
        pulse;
        drain("wrap");
        chk("wrap_cnt", frame_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
